// File: rtl/tcdm_req_resp_buffer.sv
// Decoupling stage in front of one TCDM crossbar port: a request FIFO feeds the crossbar,
// a response FIFO returns read data, and credits guarantee every response has a slot.
module tcdm_req_resp_buffer #(
    parameter int unsigned BankAddrWidth = 2,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32,
    parameter int unsigned ReqDepth      = 2,
    parameter int unsigned RespDepth     = 4,
    parameter int unsigned RespLat       = 1,
    parameter bit          WriteRespOn   = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [BankAddrWidth-1:0] req_add_i,
    input  logic                     req_wen_i,
    input  logic [ReqDataWidth-1:0]  req_wdata_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [RespDataWidth-1:0] resp_rdata_o,
    output logic                     xbar_req_o,
    output logic [BankAddrWidth-1:0] xbar_add_o,
    output logic                     xbar_wen_o,
    output logic [ReqDataWidth-1:0]  xbar_wdata_o,
    input  logic                     xbar_gnt_i,
    input  logic                     xbar_vld_i,
    input  logic [RespDataWidth-1:0] xbar_rdata_i
);

    localparam int unsigned RqPtrW = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
    localparam int unsigned RqCntW = $clog2(ReqDepth + 1);
    localparam int unsigned RsPtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam int unsigned CntW   = $clog2(RespDepth + 1);

    typedef struct packed {
        logic [BankAddrWidth-1:0] add;
        logic                     wen;
        logic [ReqDataWidth-1:0]  wdata;
    } req_t;

    req_t                     rq_mem_q [ReqDepth];
    logic [RqPtrW-1:0]        rq_wptr_q, rq_wptr_d, rq_rptr_q, rq_rptr_d;
    logic [RqCntW-1:0]        rq_cnt_q, rq_cnt_d;
    logic [RespDataWidth-1:0] rs_mem_q [RespDepth];
    logic [RsPtrW-1:0]        rs_wptr_q, rs_wptr_d, rs_rptr_q, rs_rptr_d;
    logic [CntW-1:0]          rs_cnt_q, rs_cnt_d;
    logic [CntW-1:0]          cnt_q, cnt_d;

    logic rq_full, rq_empty, rq_push, issue, needs_resp;
    logic rs_full, rs_empty, rs_push, rs_pop;
    req_t head;

    assign rq_full     = (rq_cnt_q == RqCntW'(ReqDepth));
    assign rq_empty    = (rq_cnt_q == '0);
    assign req_ready_o = rst_ni & ~rq_full;
    assign rq_push     = req_valid_i & req_ready_o;

    assign head       = rq_empty ? '0 : rq_mem_q[rq_rptr_q];
    assign needs_resp = ~head.wen | WriteRespOn;
    // Issue only with a free response slot; registered cnt_q keeps the check off the pop path.
    assign xbar_req_o   = ~rq_empty & ((cnt_q < CntW'(RespDepth)) | ~needs_resp);
    assign issue        = xbar_req_o & xbar_gnt_i;
    assign xbar_add_o   = head.add;
    assign xbar_wen_o   = head.wen;
    assign xbar_wdata_o = head.wdata;

    assign rs_empty     = (rs_cnt_q == '0);
    assign rs_full      = (rs_cnt_q == CntW'(RespDepth));
    assign resp_valid_o = ~rs_empty;
    assign resp_rdata_o = rs_empty ? '0 : rs_mem_q[rs_rptr_q];
    assign rs_pop       = resp_valid_o & resp_ready_i;
    // Responses still in flight = owed minus buffered; stray valids outside that window are dropped.
    assign rs_push      = xbar_vld_i & (cnt_q > rs_cnt_q);

    always_comb begin
        rq_wptr_d = rq_wptr_q;
        rq_rptr_d = rq_rptr_q;
        rs_wptr_d = rs_wptr_q;
        rs_rptr_d = rs_rptr_q;
        if (rq_push) rq_wptr_d = (rq_wptr_q == RqPtrW'(ReqDepth - 1)) ? '0 : rq_wptr_q + 1'b1;
        if (issue)   rq_rptr_d = (rq_rptr_q == RqPtrW'(ReqDepth - 1)) ? '0 : rq_rptr_q + 1'b1;
        if (rs_push) rs_wptr_d = (rs_wptr_q == RsPtrW'(RespDepth - 1)) ? '0 : rs_wptr_q + 1'b1;
        if (rs_pop)  rs_rptr_d = (rs_rptr_q == RsPtrW'(RespDepth - 1)) ? '0 : rs_rptr_q + 1'b1;
        rq_cnt_d = rq_cnt_q + RqCntW'(rq_push) - RqCntW'(issue);
        rs_cnt_d = rs_cnt_q + CntW'(rs_push) - CntW'(rs_pop);
        cnt_d    = cnt_q + CntW'(issue & needs_resp) - CntW'(rs_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rq_wptr_q <= '0;
            rq_rptr_q <= '0;
            rq_cnt_q  <= '0;
            rs_wptr_q <= '0;
            rs_rptr_q <= '0;
            rs_cnt_q  <= '0;
            cnt_q     <= '0;
        end else begin
            rq_wptr_q <= rq_wptr_d;
            rq_rptr_q <= rq_rptr_d;
            rq_cnt_q  <= rq_cnt_d;
            rs_wptr_q <= rs_wptr_d;
            rs_rptr_q <= rs_rptr_d;
            rs_cnt_q  <= rs_cnt_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rq_push) rq_mem_q[rq_wptr_q] <= '{add: req_add_i, wen: req_wen_i, wdata: req_wdata_i};
        if (rs_push) rs_mem_q[rs_wptr_q] <= xbar_rdata_i;
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        assert (ReqDepth > 0 && RespDepth > 0 && RespLat > 0);
        if (rst_ni) begin
            assert (!(xbar_vld_i && rs_full));
            assert (!(xbar_vld_i && (cnt_q <= rs_cnt_q)));
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (xbar_req_o && !xbar_gnt_i) |=> (xbar_req_o && $stable({xbar_add_o, xbar_wen_o, xbar_wdata_o})));
`endif

endmodule
